ecc_operand_loader: RTL
=======================

// Module: ecc_operand_loader
// PURPOSE
//  Parametrised serial-to-parallel operand loader feeding the ECC datapath (Control/GFAU/key_shift).
//  Assembles NOPS operands (Px, Py, prime, a, k, ...) of OPW bits each from DW-bit beats under valid/ready flow control.
//  Supports LSB- or MSB-first beat order, load abort/restart and explicit clear.
//  Raises a sticky load-done flag when every operand is complete.
// PARAMETERS
//  OPW       32  operand width in bits; OPW % DW == 0 required (elaboration-time $error otherwise)
//  DW        4   beat width per operand channel, 1..OPW
//  NOPS      5   number of operand channels loaded in parallel
//  MSB_FIRST 0   0: beat n fills bits [n*DW +: DW]; 1: first beat lands in the top DW bits
// PORTS
//  i_clk          in   1          clock, all state updates on rising edge
//  i_rst_n        in   1          asynchronous active-low reset
//  i_start        in   1          begin a new load; clears operands and the beat count
//  i_clear        in   1          return to IDLE and zero all operands; ignored if i_start is high
//  i_valid        in   1          beat present on i_data
//  i_data         in   NOPS*DW    channel c occupies [c*DW +: DW]
//  o_ready        out  1          beat accepted when i_valid && o_ready
//  o_busy         out  1          high in LOAD
//  o_load_done    out  1          high in DONE (sticky)
//  o_beat_cnt     out  CLOG2(BEATS+1)  accepted beats in current load, BEATS = OPW/DW
//  o_operands     out  NOPS*OPW   operand c at [c*OPW +: OPW]; stable whenever o_load_done is high
// BEHAVIOUR
//  Reset (i_rst_n low, async): state=IDLE; all outputs 0, including operands and count.
//  States: IDLE -> LOAD on i_start; LOAD -> DONE on acceptance of beat BEATS-1; DONE -> LOAD on i_start;
//    DONE/LOAD -> IDLE on i_clear (without i_start).
//  IDLE: o_ready=0, i_valid ignored.
//  i_start (any state): next cycle state=LOAD, operands=0, o_beat_cnt=0, o_load_done=0. A beat on the start
//    cycle is NOT captured. Restart mid-LOAD discards partial data.
//  LOAD: o_ready=1 (combinational from state). Each accepted beat updates all NOPS channels in the same
//    cycle and increments o_beat_cnt.
//    LSB-first: op[c][cnt*DW +: DW] <= data[c].
//    MSB-first: op[c] <= {op[c][OPW-DW-1:0], data[c]}. For DW==OPW, op[c] <= data[c].
//  Last beat: o_load_done=1 and o_busy=0 from the following cycle. o_beat_cnt holds BEATS.
//    Latency from start is BEATS+1 cycles with continuous valid.
//  DONE: o_ready=0, i_valid ignored, operands and flag held until i_start/i_clear/reset.
//  Simultaneous i_start and i_clear: i_start wins. A simultaneous beat with i_start or i_clear is discarded.
//  Counter never wraps: acceptance is impossible outside LOAD.
// STRUCTURE
//  ecc_pkg: state localparams (ST_IDLE/ST_LOAD/ST_DONE, 2-bit), clog2 function, default ECC_OPW=32.
//  Sub-module ecc_load_lane (one operand channel: OPW register plus LSB/MSB insert logic).
//    Instanced NOPS times in a generate loop.
//  Top holds FSM and beat counter only.
// TESTING
//  1 Defaults, LSB-first: start, then 8 back-to-back beats with channel0 nibbles 1..8 -> op0=0x87654321,
//    load_done rises 1 cycle after beat 8, beat_cnt=8.
//  2 MSB_FIRST=1, same stream -> op0=0x12345678; other channels checked with distinct patterns.
//  3 Valid gaps: random deassertion of i_valid -> same result as test 1; count advances only on accept.
//  4 Restart: i_start after 3 beats, then 8 new beats 0xF..0x8 -> op0=0x89ABCDEF, no residue of old data.
//  5 Reset: drop i_rst_n mid-LOAD -> all outputs 0 immediately (async); recovery load then succeeds.
//  6 DONE hold / clear: i_valid with 0xA beats in DONE -> operands unchanged, ready=0.
//    i_clear -> IDLE, operands 0. i_start+i_clear together -> LOAD.

Source files
------------

// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared constants and helpers for the ECC operand loader
package ecc_pkg;

    localparam int ECC_OPW = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Ceiling log2, at least 1 so a count of 0..1 still gets one bit
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ecc_load_lane.sv
// rtl/ecc_load_lane.sv - one operand channel: OPW register with LSB/MSB-first beat insertion
module ecc_load_lane
    import ecc_pkg::*;
#(
    parameter int OPW       = ECC_OPW,
    parameter int DW        = 4,
    parameter int IW        = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_clr,
    input  logic           i_we,
    input  logic [IW-1:0]  i_idx,
    input  logic [DW-1:0]  i_data,
    output logic [OPW-1:0] o_op
);

    logic [OPW-1:0] op_q;
    logic [OPW-1:0] op_d;
    logic [OPW-1:0] op_ins;

    // Operand value after inserting the current beat
    generate
        if (MSB_FIRST) begin : g_msb
            logic unused_idx;
            assign unused_idx = ^i_idx;
            if (DW == OPW) begin : g_full
                assign op_ins = i_data;
            end else begin : g_shift
                assign op_ins = {op_q[OPW-DW-1:0], i_data};
            end
        end else begin : g_lsb
            // Replace only the slot addressed by the beat index
            always_comb begin
                op_ins = op_q;
                op_ins[int'(i_idx)*DW +: DW] = i_data;
            end
        end
    endgenerate

    // Clear dominates a write so a beat coinciding with start/clear is dropped
    always_comb begin
        op_d = op_q;
        if (i_clr) begin
            op_d = '0;
        end else if (i_we) begin
            op_d = op_ins;
        end
    end

    // Operand register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_q <= '0;
        end else begin
            op_q <= op_d;
        end
    end

    assign o_op = op_q;

endmodule

// File: rtl/ecc_operand_loader.sv
// rtl/ecc_operand_loader.sv - serial-to-parallel operand loader: FSM, beat counter and lane array
module ecc_operand_loader
    import ecc_pkg::*;
#(
    parameter int OPW       = ECC_OPW,
    parameter int DW        = 4,
    parameter int NOPS      = 5,
    parameter bit MSB_FIRST = 1'b0,
    localparam int BEATS    = OPW / DW,
    localparam int CW       = clog2(BEATS + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_clear,
    input  logic                i_valid,
    input  logic [NOPS*DW-1:0]  i_data,
    output logic                o_ready,
    output logic                o_busy,
    output logic                o_load_done,
    output logic [CW-1:0]       o_beat_cnt,
    output logic [NOPS*OPW-1:0] o_operands
);

    generate
        if ((OPW % DW) != 0) begin : g_bad_width
            $error("ecc_operand_loader: OPW must be a multiple of DW");
        end
    endgenerate

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          accept;
    logic          lane_clr;

    // A beat is taken only in LOAD and only when no control request is pending
    assign accept   = (state_q == ST_LOAD) && i_valid && !i_start && !i_clear;
    assign lane_clr = i_start || i_clear;

    // Next state and beat count; start beats clear, clear beats a beat
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (i_start) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
        end else if (i_clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(BEATS - 1)) begin
                state_d = ST_DONE;
            end
        end
    end

    // State and counter registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_ready     = (state_q == ST_LOAD);
    assign o_busy      = (state_q == ST_LOAD);
    assign o_load_done = (state_q == ST_DONE);
    assign o_beat_cnt  = cnt_q;

    generate
        for (genvar c = 0; c < NOPS; c++) begin : g_lane
            ecc_load_lane #(
                .OPW       (OPW),
                .DW        (DW),
                .IW        (CW),
                .MSB_FIRST (MSB_FIRST)
            ) u_lane (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_clr   (lane_clr),
                .i_we    (accept),
                .i_idx   (cnt_q),
                .i_data  (i_data[c*DW +: DW]),
                .o_op    (o_operands[c*OPW +: OPW])
            );
        end
    endgenerate

endmodule
